sample_iter: RTL and testbench
==============================

# sample_iter

Sample iterator for the rasterizer. It accepts one bounding-boxed triangle at a time from the bounding-box stage (R13). It then walks every sample location inside the box in raster order, issuing one candidate sample per cycle toward the hash/jitter stage and sample test (R14 onward). The block owns the triangle/box registers and the halt backpressure between the two.

## Interface
Parameters:
- SIGFIG, 24, bits in position/color
- RADIX, 10, fraction bits; one pixel = 1<<RADIX
- VERTS, 3, vertices per triangle
- AXIS, 3, axes per vertex
- COLORS, 3, color channels

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- tri_R13S  in  [VERTS][AXIS]×SIGFIG signed  input triangle
- color_R13U  in  [COLORS]×SIGFIG  triangle color
- box_R13S  in  [2][2]×SIGFIG signed  box; [0]=lower-left (x,y), [1]=upper-right (x,y)
- validTri_R13H  in  1  triangle/box valid
- subSample_RnnnnU  in  4  one-hot MSAA mode (static per frame)
- halt_RnnnnL  in  1  downstream halt, active-low (0 = stall)
- halt_R13L  out  1  upstream halt, active-low (1 = ready to accept)
- tri_R14S, color_R14U  out  as inputs  latched triangle/color
- sample_R14S  out  [2]×SIGFIG signed  current sample (x,y)
- validSamp_R14H  out  1  sample valid

## Operation
- Step size:
  - 4'b1000 → 1<<RADIX
  - 4'b0100 → 1<<(RADIX-1)
  - 4'b0010 → 1<<(RADIX-2)
  - 4'b0001 → 1<<(RADIX-3)
  - Any other value → 1<<RADIX
- Box corners arrive already snapped to the step grid.
- Two states, WAIT and TEST:
  - **WAIT.** halt_R13L=1 and validSamp_R14H=0.
    - If validTri_R13H=1 and the box is legal (ur.x≥ll.x, ur.y≥ll.y): latch tri, color and box, set sample=ll, go to TEST.
    - An illegal box is consumed and dropped; stay in WAIT.
  - **TEST.** halt_R13L=0 and validSamp_R14H=1.
    - Advance only on cycles with halt_RnnnnL=1.
    - If x≠ur.x: x+=step.
    - Else if y≠ur.y: x=ll.x, y+=step.
    - Else (last sample): go to WAIT.
    - When halt_RnnnnL=0, all outputs and state hold.
- Next-x/next-y adders are SIGFIG+1 bits wide. The comparison uses equality against ur, so there is no overflow or wrap.
- Upstream inputs are ignored while in TEST.

## Timing
- Reset values: state=WAIT, validSamp_R14H=0, halt_R13L=1, sample_R14S=0, tri_R14S=0, color_R14U=0.
- Reset mid-iteration abandons the current triangle on the next edge.
- All outputs are registered.
- Latency: the first sample appears the cycle after the accept edge.
- Throughput: one sample per unstalled cycle. An N-sample box occupies N unstalled cycles in TEST.
- Without the macro (see Configuration), one WAIT cycle separates consecutive triangles.
- The accept handshake is validTri_R13H=1 with halt_R13L=1 on the same edge.
- Simultaneous last sample + downstream stall: the last sample holds and the WAIT transition waits for halt_RnnnnL=1.

## Configuration
- SAMPLE_ITER_BACK_TO_BACK_EN
  - Defined: halt_R13L is also driven 1 during TEST when the current sample is the last and halt_RnnnnL=1. A valid legal triangle present on that edge is latched directly, and TEST continues with its ll sample. No bubble.
  - Undefined: halt_R13L=0 throughout TEST, and one WAIT cycle occurs between triangles.

## Structure
- Shared package rast_pkg holds:
  - the state enum (WAIT/TEST)
  - subSample-to-step localparams
  - a box typedef ([2][2] signed)
- One sub-module: sample_iter_step, combinational. It computes the next (x,y) and a last flag from current sample, box and step.

## Test plan
1. RADIX=10, box (0,0)-(1024,1024), subSample 4'b1000 → samples (0,0), (1024,0), (0,1024), (1024,1024) on 4 consecutive cycles, then validSamp=0 and halt_R13L=1.
2. Same box, 4'b0100 → 9 samples with step 512, row-major, last (1024,1024).
3. Test 1 with halt_RnnnnL=0 for 3 cycles while showing (1024,0) → (1024,0) held 4 cycles, then sequence resumes unchanged.
4. Box (2048,3072)-(2048,3072) → exactly one sample (2048,3072). Box ll.x=1024, ur.x=0 → dropped, no validSamp.
5. rst asserted during sample 2 of test 1 → next cycle validSamp=0, halt_R13L=1, all outputs 0. A triangle offered afterwards iterates from its ll.
6. Two triangles offered back-to-back → macro undefined: 1 idle cycle between last and first samples; macro defined: 0 idle cycles.

Source files
------------

// File: rtl/rast_pkg.sv
// Shared rasterizer types: iterator state, MSAA step selection and the bounding box type.
package rast_pkg;

  localparam int RAST_SIGFIG = 24;
  localparam int RAST_RADIX  = 10;
  localparam int RAST_VERTS  = 3;
  localparam int RAST_AXIS   = 3;
  localparam int RAST_COLORS = 3;

  typedef enum logic {
    ST_WAIT = 1'b0,
    ST_TEST = 1'b1
  } iter_state_e;

  // One-hot MSAA codes and the right-shift applied to a full pixel step
  localparam logic [3:0] SS_1X  = 4'b1000;
  localparam logic [3:0] SS_4X  = 4'b0100;
  localparam logic [3:0] SS_16X = 4'b0010;
  localparam logic [3:0] SS_64X = 4'b0001;

  localparam logic [1:0] SHIFT_1X  = 2'd0;
  localparam logic [1:0] SHIFT_4X  = 2'd1;
  localparam logic [1:0] SHIFT_16X = 2'd2;
  localparam logic [1:0] SHIFT_64X = 2'd3;

  // [0] = lower-left (x,y), [1] = upper-right (x,y); inner [0] = x, [1] = y
  typedef logic signed [1:0][1:0][RAST_SIGFIG-1:0] box_t;

  function automatic logic [1:0] step_shift(input logic [3:0] ss);
    logic [1:0] sh;
    case (ss)
      SS_1X:   sh = SHIFT_1X;
      SS_4X:   sh = SHIFT_4X;
      SS_16X:  sh = SHIFT_16X;
      SS_64X:  sh = SHIFT_64X;
      default: sh = SHIFT_1X;
    endcase
    return sh;
  endfunction

endpackage

// File: rtl/sample_iter_step.sv
// Combinational raster-order stepper: next (x,y) inside the box and a flag for the final sample.
module sample_iter_step #(
  parameter int SIGFIG = 24
) (
  input  logic [1:0][SIGFIG-1:0]      i_sample,
  input  logic [1:0][1:0][SIGFIG-1:0] i_box,
  input  logic [SIGFIG-1:0]           i_step,
  output logic [1:0][SIGFIG-1:0]      o_next,
  output logic                        o_last
);

  logic [SIGFIG:0] w_x_sum;
  logic [SIGFIG:0] w_y_sum;
  logic            w_x_end;
  logic            w_y_end;
  logic            w_unused_carry;

  // Equality against the upper-right corner ends a row, so the carry never matters
  assign w_x_sum = {i_sample[0][SIGFIG-1], i_sample[0]} + {1'b0, i_step};
  assign w_y_sum = {i_sample[1][SIGFIG-1], i_sample[1]} + {1'b0, i_step};
  assign w_unused_carry = w_x_sum[SIGFIG] ^ w_y_sum[SIGFIG];

  assign w_x_end = (i_sample[0] == i_box[1][0]);
  assign w_y_end = (i_sample[1] == i_box[1][1]);
  assign o_last  = w_x_end & w_y_end;

  always_comb begin
    o_next = i_sample;
    if (!w_x_end) begin
      o_next[0] = w_x_sum[SIGFIG-1:0];
    end else if (!w_y_end) begin
      o_next[0] = i_box[0][0];
      o_next[1] = w_y_sum[SIGFIG-1:0];
    end
  end

endmodule

// File: rtl/sample_iter.sv
// Sample iterator: latches one boxed triangle, walks its samples in raster order (first sample one cycle after accept).
// halt_RnnnnL=0 freezes all state; SAMPLE_ITER_BACK_TO_BACK_EN lets the next triangle load on the last-sample edge.
module sample_iter
  import rast_pkg::*;
#(
  parameter int SIGFIG = RAST_SIGFIG,
  parameter int RADIX  = RAST_RADIX,
  parameter int VERTS  = RAST_VERTS,
  parameter int AXIS   = RAST_AXIS,
  parameter int COLORS = RAST_COLORS
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S,
  input  logic        [COLORS-1:0][SIGFIG-1:0]          color_R13U,
  input  logic signed [1:0][1:0][SIGFIG-1:0]            box_R13S,
  input  logic                                        validTri_R13H,
  input  logic [3:0]                                  subSample_RnnnnU,
  input  logic                                        halt_RnnnnL,
  output logic                                        halt_R13L,
  output logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S,
  output logic        [COLORS-1:0][SIGFIG-1:0]          color_R14U,
  output logic signed [1:0][SIGFIG-1:0]                 sample_R14S,
  output logic                                        validSamp_R14H
);

  localparam logic [SIGFIG-1:0] STEP_FULL = SIGFIG'(1) << RADIX;

  iter_state_e r_state;
  iter_state_e w_state_nxt;

  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] r_tri;
  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] w_tri_nxt;
  logic        [COLORS-1:0][SIGFIG-1:0]          r_color;
  logic        [COLORS-1:0][SIGFIG-1:0]          w_color_nxt;
  logic signed [1:0][1:0][SIGFIG-1:0]            r_box;
  logic signed [1:0][1:0][SIGFIG-1:0]            w_box_nxt;
  logic signed [1:0][SIGFIG-1:0]                 r_sample;
  logic signed [1:0][SIGFIG-1:0]                 w_sample_nxt;

  logic [1:0]              w_shift;
  logic [SIGFIG-1:0]       w_step;
  logic [1:0][SIGFIG-1:0]  w_step_next;
  logic                    w_last;
  logic                    w_in_legal;
  logic                    w_load;

  assign w_shift = step_shift(subSample_RnnnnU);
  assign w_step  = STEP_FULL >> w_shift;

  // A box with ur below ll on either axis holds no samples
  assign w_in_legal = ($signed(box_R13S[1][0]) >= $signed(box_R13S[0][0])) &&
                      ($signed(box_R13S[1][1]) >= $signed(box_R13S[0][1]));

  sample_iter_step #(
    .SIGFIG (SIGFIG)
  ) u_step (
    .i_sample (r_sample),
    .i_box    (r_box),
    .i_step   (w_step),
    .o_next   (w_step_next),
    .o_last   (w_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_WAIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      ST_WAIT: begin
        if (validTri_R13H && w_in_legal) begin
          w_load      = 1'b1;
          w_state_nxt = ST_TEST;
        end
      end
      ST_TEST: begin
        if (halt_RnnnnL && w_last) begin
`ifdef SAMPLE_ITER_BACK_TO_BACK_EN
          if (validTri_R13H && w_in_legal) begin
            w_load = 1'b1;
          end else begin
            w_state_nxt = ST_WAIT;
          end
`else
          w_state_nxt = ST_WAIT;
`endif
        end
      end
      default: w_state_nxt = ST_WAIT;
    endcase
  end

  always_comb begin
    w_tri_nxt    = r_tri;
    w_color_nxt  = r_color;
    w_box_nxt    = r_box;
    w_sample_nxt = r_sample;
    if (w_load) begin
      w_tri_nxt    = tri_R13S;
      w_color_nxt  = color_R13U;
      w_box_nxt    = box_R13S;
      w_sample_nxt = box_R13S[0];
    end else if (r_state == ST_TEST && halt_RnnnnL && !w_last) begin
      w_sample_nxt = w_step_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tri    <= '0;
      r_color  <= '0;
      r_box    <= '0;
      r_sample <= '0;
    end else begin
      r_tri    <= w_tri_nxt;
      r_color  <= w_color_nxt;
      r_box    <= w_box_nxt;
      r_sample <= w_sample_nxt;
    end
  end

`ifdef SAMPLE_ITER_BACK_TO_BACK_EN
  assign halt_R13L = (r_state == ST_WAIT) || (w_last && halt_RnnnnL);
`else
  assign halt_R13L = (r_state == ST_WAIT);
`endif

  assign validSamp_R14H = (r_state == ST_TEST);
  assign tri_R14S       = r_tri;
  assign color_R14U     = r_color;
  assign sample_R14S    = r_sample;

endmodule

// File: tb/tb_sample_iter.sv
// Scoreboarded bench for sample_iter: directed box cases, stalls, reset and random triangles against a raster-walk model.
`timescale 1ns/1ps
module tb_sample_iter;
  import rast_pkg::*;

  localparam int SF = 24;
  localparam int RX = 10;
`ifdef SAMPLE_ITER_BACK_TO_BACK_EN
  localparam int EXP_GAP = 0;
`else
  localparam int EXP_GAP = 1;
`endif

  typedef logic [2:0][2:0][SF-1:0] tri_t;
  typedef logic [2:0][SF-1:0]      col_t;
  typedef logic [1:0][SF-1:0]      smp_t;

  typedef struct {
    tri_t t;
    col_t c;
    box_t b;
    bit   gap;
  } drv_t;

  typedef struct {
    smp_t s;
    tri_t t;
    col_t c;
    bit   first;
    bit   gap;
    int   acc;
    bit   seen;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic signed [2:0][2:0][SF-1:0] tri_R13S;
  logic [2:0][SF-1:0] color_R13U;
  logic signed [1:0][1:0][SF-1:0] box_R13S;
  logic validTri_R13H;
  logic [3:0] subSample_RnnnnU;
  logic halt_RnnnnL;
  logic halt_R13L;
  logic signed [2:0][2:0][SF-1:0] tri_R14S;
  logic [2:0][SF-1:0] color_R14U;
  logic signed [1:0][SF-1:0] sample_R14S;
  logic validSamp_R14H;

  sample_iter dut (
    .clk              (clk),
    .rst              (rst),
    .tri_R13S         (tri_R13S),
    .color_R13U       (color_R13U),
    .box_R13S         (box_R13S),
    .validTri_R13H    (validTri_R13H),
    .subSample_RnnnnU (subSample_RnnnnU),
    .halt_RnnnnL      (halt_RnnnnL),
    .halt_R13L        (halt_R13L),
    .tri_R14S         (tri_R14S),
    .color_R14U       (color_R14U),
    .sample_R14S      (sample_R14S),
    .validSamp_R14H   (validSamp_R14H)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int n_cons = 0;
  int n_acc  = 0;
  bit stall_en = 1'b0;
  bit halt_req = 1'b1;
  drv_t drv_q[$];
  exp_t exp_q[$];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int step_of(input logic [3:0] ss);
    case (ss)
      4'b1000: return 1 << RX;
      4'b0100: return 1 << (RX - 1);
      4'b0010: return 1 << (RX - 2);
      4'b0001: return 1 << (RX - 3);
      default: return 1 << RX;
    endcase
  endfunction

  function automatic drv_t mk(input int llx, input int lly, input int urx, input int ury, input bit gap);
    drv_t d;
    for (int v = 0; v < 3; v++) begin
      for (int a = 0; a < 3; a++) d.t[v][a] = SF'($urandom);
      d.c[v] = SF'($urandom);
    end
    d.b[0][0] = SF'(llx);
    d.b[0][1] = SF'(lly);
    d.b[1][0] = SF'(urx);
    d.b[1][1] = SF'(ury);
    d.gap = gap;
    return d;
  endfunction

  // Reference: every grid point of the box, rows bottom to top, left to right
  task automatic model_accept(input drv_t d, input int acc);
    int llx, lly, urx, ury, st;
    bit f;
    exp_t e;
    llx = int'($signed(d.b[0][0]));
    lly = int'($signed(d.b[0][1]));
    urx = int'($signed(d.b[1][0]));
    ury = int'($signed(d.b[1][1]));
    st  = step_of(subSample_RnnnnU);
    f   = 1'b1;
    if (urx >= llx && ury >= lly) begin
      for (int y = lly; y <= ury; y += st) begin
        for (int x = llx; x <= urx; x += st) begin
          e.s[0] = SF'(x);
          e.s[1] = SF'(y);
          e.t = d.t;
          e.c = d.c;
          e.first = f;
          e.gap = d.gap;
          e.acc = acc;
          e.seen = 1'b0;
          exp_q.push_back(e);
          f = 1'b0;
        end
      end
    end
  endtask

  initial begin : driver
    validTri_R13H = 1'b0;
    tri_R13S = '0;
    color_R13U = '0;
    box_R13S = '0;
    forever begin
      @(posedge clk);
      #1;
      if (drv_q.size() > 0) begin
        tri_R13S = drv_q[0].t;
        color_R13U = drv_q[0].c;
        box_R13S = drv_q[0].b;
        validTri_R13H = 1'b1;
      end else begin
        validTri_R13H = 1'b0;
      end
      @(negedge clk);
      if (validTri_R13H && halt_R13L && !rst) begin
        model_accept(drv_q[0], cyc);
        drv_q.pop_front();
        n_acc++;
      end
    end
  end

  initial begin : stall_gen
    halt_RnnnnL = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      halt_RnnnnL = stall_en ? ($urandom_range(0, 3) != 0) : halt_req;
    end
  end

  initial begin : monitor
    int idle;
    exp_t e;
    idle = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        idle = 0;
      end else if (!validSamp_R14H) begin
        idle++;
      end else if (exp_q.size() == 0) begin
        chk("unexpected_sample", {1'b1, sample_R14S}, '0);
      end else begin
        if (exp_q[0].first && !exp_q[0].seen) begin
          chk("first_latency", cyc - exp_q[0].acc, 1);
          exp_q[0].seen = 1'b1;
        end
        if (halt_RnnnnL) begin
          e = exp_q.pop_front();
          chk("sample_xy", smp_t'(sample_R14S), e.s);
          chk("tri_color", {tri_t'(tri_R14S), color_R14U}, {e.t, e.c});
          if (e.first && e.gap) chk("tri_gap", idle, EXP_GAP);
          idle = 0;
          n_cons++;
        end
      end
    end
  end

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((drv_q.size() > 0 || exp_q.size() > 0 || validSamp_R14H) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL drain_timeout: pending %0d expected samples, required 0", exp_q.size());
    end
  endtask

  task automatic wait_cons(input int target, input int budget);
    int n;
    n = 0;
    while (n_cons < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (n_cons < target) begin
      errors++;
      $display("FAIL wait_cons_timeout: got %0d consumed, required %0d", n_cons, target);
    end
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int c0, a0, st, llx, lly, w, h;
    logic [3:0] modes [5];
    modes[0] = 4'b1000; modes[1] = 4'b0100; modes[2] = 4'b0010;
    modes[3] = 4'b0001; modes[4] = 4'b0110;
    rst = 1'b1;
    subSample_RnnnnU = 4'b1000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", validSamp_R14H, 0);
    chk("rst_halt", halt_R13L, 1);
    chk("rst_sample", sample_R14S, 0);
    chk("rst_tri", tri_R14S, 0);
    chk("rst_color", color_R14U, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // 2x2 pixel box at full-pixel step
    c0 = n_cons;
    drv_q.push_back(mk(0, 0, 1024, 1024, 0));
    drain(200);
    chk("t1_count", n_cons - c0, 4);
    @(negedge clk);
    chk("t1_idle_valid", validSamp_R14H, 0);
    chk("t1_idle_halt", halt_R13L, 1);

    subSample_RnnnnU = 4'b0100;
    c0 = n_cons;
    drv_q.push_back(mk(0, 0, 1024, 1024, 0));
    drain(200);
    chk("t2_count", n_cons - c0, 9);
    subSample_RnnnnU = 4'b1000;

    // Stall while (1024,0) is on the output
    c0 = n_cons;
    drv_q.push_back(mk(0, 0, 1024, 1024, 0));
    wait_cons(c0 + 1, 50);
    #1 halt_req = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t3_hold", {validSamp_R14H, sample_R14S}, {1'b1, SF'(0), SF'(1024)});
    end
    @(posedge clk);
    #1 halt_req = 1'b1;
    drain(200);
    chk("t3_count", n_cons - c0, 4);

    c0 = n_cons;
    drv_q.push_back(mk(2048, 3072, 2048, 3072, 0));
    drain(200);
    chk("t4_single", n_cons - c0, 1);
    a0 = n_acc;
    c0 = n_cons;
    drv_q.push_back(mk(1024, 0, 0, 0, 0));
    drv_q.push_back(mk(0, 1024, 0, 0, 0));
    drain(200);
    chk("t4_illegal_taken", n_acc - a0, 2);
    repeat (2) @(negedge clk);
    chk("t4_illegal_nosamp", {validSamp_R14H, 32'(n_cons - c0)}, 0);

    // Reset while the second sample is showing
    c0 = n_cons;
    drv_q.push_back(mk(0, 0, 1024, 1024, 0));
    wait_cons(c0 + 1, 50);
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t5_valid", validSamp_R14H, 0);
    chk("t5_halt", halt_R13L, 1);
    chk("t5_outputs", {sample_R14S, tri_R14S, color_R14U}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    c0 = n_cons;
    drv_q.push_back(mk(-1024, -1024, 0, 0, 0));
    drain(200);
    chk("t5_after_count", n_cons - c0, 4);

    // Back-to-back pair; gap measured on the second triangle
    drv_q.push_back(mk(0, 0, 1024, 0, 0));
    drv_q.push_back(mk(4096, 4096, 5120, 4096, 1));
    drv_q.push_back(mk(-2048, 0, -2048, 0, 1));
    drain(200);

    stall_en = 1'b1;
    for (int m = 0; m < 5; m++) begin
      subSample_RnnnnU = modes[m];
      st = step_of(modes[m]);
      for (int k = 0; k < 8; k++) begin
        llx = (int'($urandom_range(0, 16)) - 8) * st;
        lly = (int'($urandom_range(0, 16)) - 8) * st;
        w = int'($urandom_range(0, 3)) * st;
        h = int'($urandom_range(0, 3)) * st;
        if ($urandom_range(0, 7) == 0) w = -st;
        drv_q.push_back(mk(llx, lly, llx + w, lly + h, 0));
      end
      drain(3000);
    end
    stall_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("sb_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
